multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 22 ++
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_RWB     = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_ADDI_EX = 4'd9;
    localparam logic [3:0] ST_ADDI_WB = 4'd10;
    localparam logic [3:0] ST_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the R-type funct field to an ALU operation; unknown funct yields NOP.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o
);

    always_comb begin
        case (funct_i)
            FUNCT_ADD: alu_op_o = ALU_ADD;
            FUNCT_SUB: alu_op_o = ALU_SUB;
            FUNCT_AND: alu_op_o = ALU_AND;
            FUNCT_OR:  alu_op_o = ALU_OR;
            FUNCT_XOR: alu_op_o = ALU_XOR;
            FUNCT_NOR: alu_op_o = ALU_NOR;
            FUNCT_SLT: alu_op_o = ALU_SLT;
            default:   alu_op_o = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state sequencing plus Moore decode of the
// datapath controls (o_pc_write in BRANCH follows i_zero).
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned OP_WIDTH    = 3,
    parameter int unsigned STATE_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [5:0]             i_opcode,
    input  logic [5:0]             i_funct,
    input  logic                   i_zero,
    output logic                   o_pc_write,
    output logic                   o_ir_write,
    output logic                   o_iord,
    output logic                   o_mem_read,
    output logic                   o_mem_write,
    output logic                   o_reg_write,
    output logic                   o_reg_dst,
    output logic                   o_mem_to_reg,
    output logic                   o_alu_src_a,
    output logic [1:0]             o_alu_src_b,
    output logic [1:0]             o_pc_src,
    output logic [OP_WIDTH-1:0]    o_alu_op,
    output logic [STATE_WIDTH-1:0] o_state
);

    localparam logic [STATE_WIDTH-1:0] S_FETCH   = STATE_WIDTH'(ST_FETCH);
    localparam logic [STATE_WIDTH-1:0] S_DECODE  = STATE_WIDTH'(ST_DECODE);
    localparam logic [STATE_WIDTH-1:0] S_MEMADR  = STATE_WIDTH'(ST_MEMADR);
    localparam logic [STATE_WIDTH-1:0] S_MEMRD   = STATE_WIDTH'(ST_MEMRD);
    localparam logic [STATE_WIDTH-1:0] S_MEMWB   = STATE_WIDTH'(ST_MEMWB);
    localparam logic [STATE_WIDTH-1:0] S_MEMWR   = STATE_WIDTH'(ST_MEMWR);
    localparam logic [STATE_WIDTH-1:0] S_EXEC    = STATE_WIDTH'(ST_EXEC);
    localparam logic [STATE_WIDTH-1:0] S_RWB     = STATE_WIDTH'(ST_RWB);
    localparam logic [STATE_WIDTH-1:0] S_BRANCH  = STATE_WIDTH'(ST_BRANCH);
    localparam logic [STATE_WIDTH-1:0] S_ADDI_EX = STATE_WIDTH'(ST_ADDI_EX);
    localparam logic [STATE_WIDTH-1:0] S_ADDI_WB = STATE_WIDTH'(ST_ADDI_WB);
    localparam logic [STATE_WIDTH-1:0] S_JUMP    = STATE_WIDTH'(ST_JUMP);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [2:0] funct_alu_op, alu_op;
    logic pc_write, ir_write, mem_read, mem_write, reg_write;

    alu_decoder u_alu_decoder (
        .funct_i  (i_funct),
        .alu_op_o (funct_alu_op)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        o_iord       = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRC_B_REG;
        o_pc_src     = PC_SRC_ALU;
        alu_op       = ALU_NOP;
        case (state_q)
            S_FETCH: begin
                mem_read    = 1'b1;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                o_alu_src_b = SRC_B_FOUR;
                alu_op      = ALU_ADD;
            end
            S_DECODE: begin
                o_alu_src_b = SRC_B_IMM_SH2;
                alu_op      = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRC_B_IMM;
                alu_op      = ALU_ADD;
            end
            S_MEMRD: begin
                o_iord   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWR: begin
                o_iord    = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_RWB: begin
                reg_write = 1'b1;
                o_reg_dst = 1'b1;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                alu_op      = funct_alu_op;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                alu_op      = ALU_SUB;
                o_pc_src    = PC_SRC_ALUOUT;
                pc_write    = i_zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                o_pc_src = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

    // State is already FETCH during reset; only the write/strobe enables need masking.
    assign o_pc_write  = pc_write  & i_rst_n;
    assign o_ir_write  = ir_write  & i_rst_n;
    assign o_mem_read  = mem_read  & i_rst_n;
    assign o_mem_write = mem_write & i_rst_n;
    assign o_reg_write = reg_write & i_rst_n;
    assign o_alu_op    = OP_WIDTH'(alu_op);
    assign o_state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction state sequences and
// control outputs compared against a table-driven reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;

    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int seq[$];

    multicycle_ctrl #(
        .OP_WIDTH    (3),
        .STATE_WIDTH (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .i_zero       (zero),
        .o_pc_write   (pc_write),
        .o_ir_write   (ir_write),
        .o_iord       (iord),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_reg_write  (reg_write),
        .o_reg_dst    (reg_dst),
        .o_mem_to_reg (mem_to_reg),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_pc_src     (pc_src),
        .o_alu_op     (alu_op),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op};

    // FETCH outputs with all enables forced low
    localparam logic [15:0] RESET_OUTS = 16'h0022;

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b100110: return 3'b101;
            6'b100111: return 3'b100;
            6'b101010: return 3'b111;
            default:   return 3'b011;
        endcase
    endfunction

    function automatic logic [15:0] ref_out(input int st, input logic [5:0] f, input logic z);
        logic pw, iw, io, mr, mw, rw, rd, m2r, sa;
        logic [1:0] sb, ps;
        logic [2:0] op;
        {pw, iw, io, mr, mw, rw, rd, m2r, sa} = '0;
        sb = 2'b00;
        ps = 2'b00;
        op = 3'b011;
        case (st)
            0:    begin mr = 1; iw = 1; pw = 1; sb = 2'b01; op = 3'b010; end
            1:    begin sb = 2'b11; op = 3'b010; end
            2, 9: begin sa = 1; sb = 2'b10; op = 3'b010; end
            3:    begin io = 1; mr = 1; end
            4:    begin rw = 1; m2r = 1; end
            5:    begin io = 1; mw = 1; end
            6:    begin sa = 1; op = ref_alu(f); end
            7:    begin rw = 1; rd = 1; end
            8:    begin sa = 1; op = 3'b110; ps = 2'b01; pw = z; end
            10:   rw = 1;
            11:   begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, iw, io, mr, mw, rw, rd, m2r, sa, sb, ps, op};
    endfunction

    task automatic build_seq(input logic [5:0] opc);
        case (opc)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b000100: seq = '{0, 1, 8};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000010: seq = '{0, 1, 11};
            default:   seq = '{0, 1};
        endcase
    endtask

    // Runs nsteps cycles of an instruction (all if nsteps < 0); inputs outside
    // the sampling states are randomised to show they are ignored.
    task automatic run_instr(input string name, input logic [5:0] opc, input logic [5:0] fn,
                             input logic z, input int nsteps);
        int n;
        build_seq(opc);
        n = (nsteps < 0) ? seq.size() : nsteps;
        for (int k = 0; k < n; k++) begin
            int st = seq[k];
            logic [15:0] exp_o;
            bit sampled = (st == 1) || (st == 2) || (st == 6);
            opcode = sampled ? opc : 6'($urandom);
            funct  = sampled ? fn  : 6'($urandom);
            zero   = (st == 8) ? z : 1'($urandom);
            #1;
            exp_o = ref_out(st, fn, z);
            n_checks++;
            if (state !== 4'(st)) begin
                n_fail++;
                $display("FAIL %s step %0d state: got %0d expected %0d", name, k, state, st);
            end
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL %s step %0d outputs: got %h expected %h", name, k, obs, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_fetch(input string name);
        n_checks++;
        if (state !== 4'd0 || obs !== ref_out(0, 6'd0, 1'b0)) begin
            n_fail++;
            $display("FAIL %s: got state %0d outs %h expected state 0 outs %h",
                     name, state, obs, ref_out(0, 6'd0, 1'b0));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (state !== 4'd0 || obs !== RESET_OUTS) begin
                n_fail++;
                $display("FAIL reset hold %0d: got state %0d outs %h expected state 0 outs %h",
                         i, state, obs, RESET_OUTS);
            end
            opcode = 6'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_fetch("reset release");
    endtask

    task automatic test_lw();
        run_instr("lw", 6'b100011, 6'($urandom), 1'($urandom), -1);
    endtask

    task automatic test_rtype_slt();
        run_instr("slt", 6'b000000, 6'b101010, 1'b0, -1);
    endtask

    task automatic test_beq();
        run_instr("beq taken", 6'b000100, 6'($urandom), 1'b1, -1);
        run_instr("beq not taken", 6'b000100, 6'($urandom), 1'b0, -1);
    endtask

    task automatic test_unsupported();
        run_instr("opcode 111111", 6'b111111, 6'($urandom), 1'b0, -1);
    endtask

    task automatic test_funct_nop();
        run_instr("funct nop", 6'b000000, 6'b000000, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b sw", 6'b101011, 6'd0, 1'b0, -1);
        run_instr("b2b addi", 6'b001000, 6'd0, 1'b0, -1);
        run_instr("b2b j", 6'b000010, 6'd0, 1'b1, -1);
        run_instr("b2b sub", 6'b000000, 6'b100010, 1'b0, -1);
        check_fetch("b2b end");
    endtask

    task automatic test_reset_mid();
        run_instr("lw pre-reset", 6'b100011, 6'd0, 1'b0, 3);
        n_checks++;
        if (state !== 4'd3) begin
            n_fail++;
            $display("FAIL mid reset setup: got state %0d expected 3", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || obs !== RESET_OUTS) begin
            n_fail++;
            $display("FAIL mid reset async: got state %0d outs %h expected state 0 outs %h",
                     state, obs, RESET_OUTS);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0 || obs !== RESET_OUTS) begin
            n_fail++;
            $display("FAIL mid reset held: got state %0d outs %h expected state 0 outs %h",
                     state, obs, RESET_OUTS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_fetch("mid reset release");
        run_instr("post-reset addi", 6'b001000, 6'd0, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b100111, 6'b101010};
        for (int i = 0; i < 60; i++) begin
            int pick = int'($urandom_range(0, 6));
            logic [5:0] opc = (pick == 6) ? 6'($urandom) : ops[pick];
            logic [5:0] fn = $urandom_range(0, 1) ? fns[$urandom_range(0, 6)] : 6'($urandom);
            run_instr("random", opc, fn, 1'($urandom), -1);
        end
        check_fetch("random end");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_slt();
        test_beq();
        test_unsupported();
        test_funct_nop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
